// File: rtl/pacman_pkg.sv
// -----------------------------------------------------------------------------
// pacman_pkg
//   Shared types and constants for the game status tracker.
//   - state_e    : tracker state (PLAY, DYING, LOST, WON)
//   - LEVEL_PLAY : game-control level encoding that enables play
//   - DEF_*_PTS  : default point values per event
//   - sat_add    : 16-bit saturating add used for the score
// -----------------------------------------------------------------------------
package pacman_pkg;

    typedef enum logic [1:0] {
        ST_PLAY  = 2'd0,
        ST_DYING = 2'd1,
        ST_LOST  = 2'd2,
        ST_WON   = 2'd3
    } state_e;

    localparam logic [1:0] LEVEL_PLAY = 2'b01;

    localparam int unsigned DEF_PELLET_PTS = 10;
    localparam int unsigned DEF_POWER_PTS  = 50;
    localparam int unsigned DEF_GHOST_PTS  = 200;

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/frame_timer.sv
// -----------------------------------------------------------------------------
// frame_timer
//   Down-counter clocked by video frame ticks.
//   Priority: clr_i > load_i > frame_tick_i decrement (stops at zero).
//   Ports:
//     clk_i, rst_i      clock, asynchronous active-high reset
//     clr_i            synchronous clear to zero
//     load_i/load_val_i synchronous load of a new count
//     frame_tick_i     decrement strobe
//     count_o          current count
//     running_o        count_o != 0
// -----------------------------------------------------------------------------
module frame_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         frame_tick_i,
    output logic [W-1:0] count_o,
    output logic         running_o
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (frame_tick_i && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o   = count_q;
    assign running_o = (count_q != '0);

endmodule

// File: rtl/game_status_tracker.sv
// -----------------------------------------------------------------------------
// game_status_tracker
//   Tracks lives, score and pellets remaining from gameplay event pulses and
//   drives sticky over/win flags to the game-control FSM.
//   Optional feature macro: FRIGHT_MODE_EN (frightened-ghost timer; when
//   undefined, frightened is tied low and power pellets only score/count).
//   Ports:
//     Clk, Reset     clock, asynchronous active-high reset
//     reseton        synchronous restart (beats every same-cycle event)
//     level          2'b01 = playing; any other value freezes the tracker
//     frame_tick     one pulse per video frame
//     pellet_eaten, power_eaten, ghost_hit   event pulses
//     over, win      sticky end-of-game flags
//     lives, score, pellets_left             game counters
//     dying          high during the death animation
//     frightened     high while the fright timer runs
// -----------------------------------------------------------------------------
module game_status_tracker
    import pacman_pkg::*;
#(
    parameter int unsigned NUM_PELLETS   = 244,
    parameter int unsigned START_LIVES   = 3,
    parameter int unsigned DEATH_FRAMES  = 120,
    parameter int unsigned FRIGHT_FRAMES = 360,
    parameter int unsigned PELLET_PTS    = DEF_PELLET_PTS,
    parameter int unsigned POWER_PTS     = DEF_POWER_PTS,
    parameter int unsigned GHOST_PTS     = DEF_GHOST_PTS,
    localparam int unsigned CW           = $clog2(NUM_PELLETS + 1)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          reseton,
    input  logic [1:0]    level,
    input  logic          frame_tick,
    input  logic          pellet_eaten,
    input  logic          power_eaten,
    input  logic          ghost_hit,
    output logic          over,
    output logic          win,
    output logic [1:0]    lives,
    output logic [15:0]   score,
    output logic [CW-1:0] pellets_left,
    output logic          dying,
    output logic          frightened
);

    localparam int unsigned DW = (DEATH_FRAMES < 1) ? 1 : $clog2(DEATH_FRAMES + 1);
    localparam logic [DW-1:0] DEATH_LOAD = DW'(DEATH_FRAMES);

    state_e          state_q, state_d;
    logic            over_q, over_d;
    logic            win_q, win_d;
    logic [1:0]      lives_q, lives_d;
    logic [15:0]     score_q, score_d;
    logic [CW-1:0]   pellets_q, pellets_d;

    logic            tick_ok;
    logic [1:0]      eat_cnt;
    logic            ate;
    logic [15:0]     sc;
    logic [DW-1:0]   death_cnt;
    logic            death_load;
    logic            death_running_unused;
    logic            fright_on;
    logic            fright_load;

    // Frame ticks only advance timers while the game-control FSM is playing.
    assign tick_ok = frame_tick && (level == LEVEL_PLAY) && !reseton;
    assign eat_cnt = {1'b0, pellet_eaten} + {1'b0, power_eaten};

    always_comb begin
        state_d     = state_q;
        over_d      = over_q;
        win_d       = win_q;
        lives_d     = lives_q;
        score_d     = score_q;
        pellets_d   = pellets_q;
        death_load  = 1'b0;
        fright_load = 1'b0;
        ate         = 1'b0;
        sc          = score_q;

        if (reseton) begin
            state_d   = ST_PLAY;
            over_d    = 1'b0;
            win_d     = 1'b0;
            lives_d   = 2'(START_LIVES);
            score_d   = '0;
            pellets_d = CW'(NUM_PELLETS);
        end else begin
            case (state_q)
                ST_PLAY: begin
                    if (level == LEVEL_PLAY) begin
                        // Pellet pulses arriving with nothing left are dropped.
                        if ((pellets_q != '0) && (eat_cnt != 2'd0)) begin
                            ate = 1'b1;
                            if (pellet_eaten) sc = sat_add(sc, 16'(PELLET_PTS));
                            if (power_eaten) begin
                                sc          = sat_add(sc, 16'(POWER_PTS));
                                fright_load = 1'b1;
                            end
                            if (32'(pellets_q) > 32'(eat_cnt)) begin
                                pellets_d = pellets_q - CW'(eat_cnt);
                            end else begin
                                pellets_d = '0;
                            end
                        end
                        // Clearing the maze wins even if a ghost touches in the same cycle.
                        if (ate && (pellets_d == '0)) begin
                            state_d = ST_WON;
                            win_d   = 1'b1;
                        end else if (ghost_hit) begin
                            if (fright_on) begin
                                sc = sat_add(sc, 16'(GHOST_PTS));
                            end else if (lives_q <= 2'd1) begin
                                state_d = ST_LOST;
                                over_d  = 1'b1;
                                lives_d = 2'd0;
                            end else begin
                                state_d    = ST_DYING;
                                lives_d    = lives_q - 2'd1;
                                death_load = 1'b1;
                            end
                        end
                        score_d = sc;
                    end
                end
                // Leave on the tick that drains the timer, so play resumes
                // exactly DEATH_FRAMES ticks after the hit.
                ST_DYING: begin
                    if (tick_ok && (death_cnt <= DW'(1))) begin
                        state_d = ST_PLAY;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_PLAY;
            over_q    <= 1'b0;
            win_q     <= 1'b0;
            lives_q   <= 2'(START_LIVES);
            score_q   <= '0;
            pellets_q <= CW'(NUM_PELLETS);
        end else begin
            state_q   <= state_d;
            over_q    <= over_d;
            win_q     <= win_d;
            lives_q   <= lives_d;
            score_q   <= score_d;
            pellets_q <= pellets_d;
        end
    end

    frame_timer #(
        .W (DW)
    ) u_death_timer (
        .clk_i        (Clk),
        .rst_i        (Reset),
        .clr_i        (reseton),
        .load_i       (death_load),
        .load_val_i   (DEATH_LOAD),
        .frame_tick_i (tick_ok && (state_q == ST_DYING)),
        .count_o      (death_cnt),
        .running_o    (death_running_unused)
    );

`ifdef FRIGHT_MODE_EN
    localparam int unsigned FW = (FRIGHT_FRAMES < 1) ? 1 : $clog2(FRIGHT_FRAMES + 1);

    logic          fright_clr;
    logic [FW-1:0] fright_cnt_unused;

    // Leaving PLAY for any reason cancels fright mode.
    assign fright_clr = reseton || (state_d != ST_PLAY);

    frame_timer #(
        .W (FW)
    ) u_fright_timer (
        .clk_i        (Clk),
        .rst_i        (Reset),
        .clr_i        (fright_clr),
        .load_i       (fright_load),
        .load_val_i   (FW'(FRIGHT_FRAMES)),
        .frame_tick_i (tick_ok && (state_q == ST_PLAY)),
        .count_o      (fright_cnt_unused),
        .running_o    (fright_on)
    );
`else
    logic fright_unused;

    assign fright_on     = 1'b0;
    assign fright_unused = fright_load ^ (FRIGHT_FRAMES == 0);
`endif

    assign over         = over_q;
    assign win          = win_q;
    assign lives        = lives_q;
    assign score        = score_q;
    assign pellets_left = pellets_q;
    assign dying        = (state_q == ST_DYING);
    assign frightened   = fright_on;

endmodule

// File: tb/tb_game_status_tracker.sv
module tb_game_status_tracker;

    localparam int unsigned NP  = 4;
    localparam int unsigned CWT = 3;
    localparam logic [1:0]  P   = 2'b01;
    localparam logic FR =
`ifdef FRIGHT_MODE_EN
        1'b1;
`else
        1'b0;
`endif

    logic           Clk = 1'b0;
    logic           Reset = 1'b1;
    logic           reseton = 1'b0;
    logic [1:0]     level = 2'b01;
    logic           frame_tick = 1'b0;
    logic           pellet_eaten = 1'b0;
    logic           power_eaten = 1'b0;
    logic           ghost_hit = 1'b0;
    logic           over, win, dying, frightened;
    logic [1:0]     lives;
    logic [15:0]    score;
    logic [CWT-1:0] pellets_left;

    game_status_tracker #(
        .NUM_PELLETS   (NP),
        .START_LIVES   (3),
        .DEATH_FRAMES  (3),
        .FRIGHT_FRAMES (8)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .reseton      (reseton),
        .level        (level),
        .frame_tick   (frame_tick),
        .pellet_eaten (pellet_eaten),
        .power_eaten  (power_eaten),
        .ghost_hit    (ghost_hit),
        .over         (over),
        .win          (win),
        .lives        (lives),
        .score        (score),
        .pellets_left (pellets_left),
        .dying        (dying),
        .frightened   (frightened)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int          id;
        logic        ov;
        logic        wn;
        logic [1:0]  lv;
        logic [15:0] sc;
        logic [CWT-1:0] pl;
        logic        dy;
        logic        fr;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   vec    = 0;

    function automatic exp_t mk(input int ov, input int wn, input int lv, input int sc,
                                input int pl, input int dy, input int fr);
        exp_t e;
        e.id = 0;
        e.ov = 1'(ov);
        e.wn = 1'(wn);
        e.lv = 2'(lv);
        e.sc = 16'(sc);
        e.pl = CWT'(pl);
        e.dy = 1'(dy);
        e.fr = 1'(fr);
        return e;
    endfunction

    task automatic chk(input string name, input int id, input logic [15:0] got,
                       input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s vec %0d got %0h expected %0h", name, id, got, want);
        end
    endtask

    // Monitor: every cycle with a pending expectation is compared after the edge.
    always @(posedge Clk) begin
        #1;
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("over",         e.id, 16'(over),         16'(e.ov));
            chk("win",          e.id, 16'(win),          16'(e.wn));
            chk("lives",        e.id, 16'(lives),        16'(e.lv));
            chk("score",        e.id, score,             e.sc);
            chk("pellets_left", e.id, 16'(pellets_left), 16'(e.pl));
            chk("dying",        e.id, 16'(dying),        16'(e.dy));
            chk("frightened",   e.id, 16'(frightened),   16'(e.fr));
        end
    end

    task automatic cyc(input logic rs, input logic [1:0] lvl, input logic ft, input logic pe,
                       input logic pw, input logic gh, input exp_t e);
        @(negedge Clk);
        reseton      = rs;
        level        = lvl;
        frame_tick   = ft;
        pellet_eaten = pe;
        power_eaten  = pw;
        ghost_hit    = gh;
        e.id         = vec;
        vec++;
        exp_q.push_back(e);
    endtask

    task automatic restart();
        cyc(1, P, 0, 0, 0, 0, mk(0, 0, 3, 0, NP, 0, 0));
    endtask

    initial begin
        repeat (2) @(negedge Clk);
        Reset = 1'b0;

        // reset state
        cyc(0, P, 0, 0, 0, 0, mk(0, 0, 3, 0, 4, 0, 0));

        // clear the maze
        cyc(0, P, 0, 1, 0, 0, mk(0, 0, 3, 10, 3, 0, 0));
        cyc(0, P, 1, 1, 0, 0, mk(0, 0, 3, 20, 2, 0, 0));
        cyc(0, P, 0, 1, 0, 0, mk(0, 0, 3, 30, 1, 0, 0));
        cyc(0, P, 0, 1, 0, 0, mk(0, 1, 3, 40, 0, 0, 0));
        cyc(0, P, 0, 1, 0, 1, mk(0, 1, 3, 40, 0, 0, 0));
        restart();

        // non-playing levels ignore events
        cyc(0, 2'b10, 0, 1, 0, 0, mk(0, 0, 3, 0, 4, 0, 0));
        cyc(0, 2'b00, 0, 0, 0, 1, mk(0, 0, 3, 0, 4, 0, 0));
        cyc(0, 2'b10, 0, 0, 1, 0, mk(0, 0, 3, 0, 4, 0, 0));

        // lose all lives
        cyc(0, P, 0, 0, 0, 1, mk(0, 0, 2, 0, 4, 1, 0));
        cyc(0, P, 0, 0, 0, 1, mk(0, 0, 2, 0, 4, 1, 0));
        cyc(0, P, 0, 1, 0, 0, mk(0, 0, 2, 0, 4, 1, 0));
        cyc(0, P, 1, 0, 0, 0, mk(0, 0, 2, 0, 4, 1, 0));
        cyc(0, 2'b10, 1, 0, 0, 0, mk(0, 0, 2, 0, 4, 1, 0));
        cyc(0, P, 1, 0, 0, 1, mk(0, 0, 2, 0, 4, 1, 0));
        cyc(0, P, 1, 0, 0, 0, mk(0, 0, 2, 0, 4, 0, 0));
        cyc(0, P, 0, 0, 0, 1, mk(0, 0, 1, 0, 4, 1, 0));
        cyc(0, P, 1, 0, 0, 0, mk(0, 0, 1, 0, 4, 1, 0));
        cyc(0, P, 1, 0, 0, 0, mk(0, 0, 1, 0, 4, 1, 0));
        cyc(0, P, 1, 0, 0, 0, mk(0, 0, 1, 0, 4, 0, 0));
        cyc(0, P, 0, 0, 0, 1, mk(1, 0, 0, 0, 4, 0, 0));
        cyc(0, P, 0, 1, 0, 1, mk(1, 0, 0, 0, 4, 0, 0));
        // restart beats a same-cycle pellet
        cyc(1, P, 0, 1, 0, 0, mk(0, 0, 3, 0, 4, 0, 0));

        // last pellet with ghost contact
        cyc(0, P, 0, 1, 0, 0, mk(0, 0, 3, 10, 3, 0, 0));
        cyc(0, P, 0, 1, 0, 0, mk(0, 0, 3, 20, 2, 0, 0));
        cyc(0, P, 0, 1, 0, 0, mk(0, 0, 3, 30, 1, 0, 0));
        cyc(0, P, 0, 1, 0, 1, mk(0, 1, 3, 40, 0, 0, 0));
        restart();

        // both pellet kinds in one cycle
        cyc(0, P, 0, 1, 1, 0, mk(0, 0, 3, 60, 2, 0, FR));
        restart();

        // score saturation from 6553 pellets' worth
        @(negedge Clk);
        reseton = 1'b0;
        force dut.score_q = 16'd65530;
        #1;
        release dut.score_q;
        cyc(0, P, 0, 1, 0, 0, mk(0, 0, 3, 16'hFFFF, 3, 0, 0));
        cyc(0, P, 0, 0, 1, 0, mk(0, 0, 3, 16'hFFFF, 2, 0, FR));
        restart();

`ifdef FRIGHT_MODE_EN
        cyc(0, P, 0, 0, 1, 0, mk(0, 0, 3, 50, 3, 0, 1));
        for (int i = 0; i < 5; i++) cyc(0, P, 1, 0, 0, 0, mk(0, 0, 3, 50, 3, 0, 1));
        cyc(0, P, 0, 0, 0, 1, mk(0, 0, 3, 250, 3, 0, 1));
        cyc(0, 2'b10, 1, 1, 0, 0, mk(0, 0, 3, 250, 3, 0, 1));
        cyc(0, P, 1, 0, 0, 0, mk(0, 0, 3, 250, 3, 0, 1));
        cyc(0, P, 1, 0, 0, 0, mk(0, 0, 3, 250, 3, 0, 1));
        cyc(0, P, 1, 0, 0, 0, mk(0, 0, 3, 250, 3, 0, 0));
        cyc(0, P, 0, 0, 0, 1, mk(0, 0, 2, 250, 3, 1, 0));
`else
        cyc(0, P, 0, 0, 1, 0, mk(0, 0, 3, 50, 3, 0, 0));
        cyc(0, P, 1, 0, 0, 0, mk(0, 0, 3, 50, 3, 0, 0));
        cyc(0, P, 0, 0, 0, 1, mk(0, 0, 2, 50, 3, 1, 0));
`endif

        @(negedge Clk);
        reseton = 1'b0; frame_tick = 1'b0; pellet_eaten = 1'b0;
        power_eaten = 1'b0; ghost_hit = 1'b0; level = P;

        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() != 0) @(negedge Clk);
        end
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
